// File: rtl/csr_file.sv
// Machine-mode CSR file with exception/mret trap sequencer and registered fetch redirect.
// Define CSR_COUNTERS_EN to add the 64-bit mcycle/minstret counters and their user shadows.
module csr_file #(
  parameter int unsigned XLEN        = 32,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter int unsigned HART_ID     = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            csr_wbk_v_i,
  input  logic [11:0]     csr_wbk_adr_i,
  input  logic [XLEN-1:0] csr_wbk_data_i,
  input  logic [11:0]     csr_rd_adr_i,
  output logic [XLEN-1:0] csr_rd_data_o,
  output logic            csr_rd_illegal_o,
  input  logic            exception_v_i,
  input  logic [XLEN-1:0] exception_cause_i,
  input  logic [XLEN-1:0] exception_pc_i,
  input  logic [XLEN-1:0] exception_tval_i,
  input  logic            mret_v_i,
  input  logic            instret_v_i,
  output logic            trap_v_q_o,
  output logic [XLEN-1:0] trap_pc_q_o
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic            r_mie;
  logic            r_mpie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;
  logic            r_trap_v;
  logic [XLEN-1:0] r_trap_pc;

  // A CSR write only lands when no trap or mret claims the cycle.
  logic w_wr;
  assign w_wr = csr_wbk_v_i & ~exception_v_i & ~mret_v_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mie  <= 1'b0;
      r_mpie <= 1'b0;
    end else if (exception_v_i) begin
      r_mpie <= r_mie;
      r_mie  <= 1'b0;
    end else if (mret_v_i) begin
      r_mie  <= r_mpie;
      r_mpie <= 1'b1;
    end else if (w_wr && csr_wbk_adr_i == A_MSTATUS) begin
      r_mie  <= csr_wbk_data_i[3];
      r_mpie <= csr_wbk_data_i[7];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mepc   <= '0;
      r_mcause <= '0;
      r_mtval  <= '0;
    end else if (exception_v_i) begin
      r_mepc   <= exception_pc_i & ALIGN_MASK;
      r_mcause <= exception_cause_i;
      r_mtval  <= exception_tval_i;
    end else if (w_wr) begin
      if (csr_wbk_adr_i == A_MEPC)   r_mepc   <= csr_wbk_data_i & ALIGN_MASK;
      if (csr_wbk_adr_i == A_MCAUSE) r_mcause <= csr_wbk_data_i;
      if (csr_wbk_adr_i == A_MTVAL)  r_mtval  <= csr_wbk_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mtvec    <= XLEN'(MTVEC_RESET);
      r_mscratch <= '0;
    end else if (w_wr) begin
      if (csr_wbk_adr_i == A_MTVEC)    r_mtvec    <= csr_wbk_data_i & ALIGN_MASK;
      if (csr_wbk_adr_i == A_MSCRATCH) r_mscratch <= csr_wbk_data_i;
    end
  end

  // Redirect targets sample mtvec/mepc before this edge's updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_trap_v  <= 1'b0;
      r_trap_pc <= '0;
    end else begin
      r_trap_v <= exception_v_i | mret_v_i;
      if (exception_v_i)  r_trap_pc <= r_mtvec;
      else if (mret_v_i)  r_trap_pc <= r_mepc;
    end
  end

  assign trap_v_q_o  = r_trap_v;
  assign trap_pc_q_o = r_trap_pc;

`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;

  logic [XLEN-1:0] r_mcycle_lo;
  logic [XLEN-1:0] r_mcycle_hi;
  logic [XLEN-1:0] r_minstret_lo;
  logic [XLEN-1:0] r_minstret_hi;
  logic            w_cy_carry;
  logic            w_ir_carry;

  // Carry comes from the low word's own increment, even if that word is overwritten.
  assign w_cy_carry = &r_mcycle_lo;
  assign w_ir_carry = instret_v_i & (&r_minstret_lo);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcycle_lo   <= '0;
      r_mcycle_hi   <= '0;
      r_minstret_lo <= '0;
      r_minstret_hi <= '0;
    end else begin
      r_mcycle_lo   <= (w_wr && csr_wbk_adr_i == A_MCYCLE)    ? csr_wbk_data_i
                                                               : r_mcycle_lo + XLEN'(1);
      r_mcycle_hi   <= (w_wr && csr_wbk_adr_i == A_MCYCLEH)   ? csr_wbk_data_i
                                                               : r_mcycle_hi + XLEN'(w_cy_carry);
      r_minstret_lo <= (w_wr && csr_wbk_adr_i == A_MINSTRET)  ? csr_wbk_data_i
                                                               : r_minstret_lo + XLEN'(instret_v_i);
      r_minstret_hi <= (w_wr && csr_wbk_adr_i == A_MINSTRETH) ? csr_wbk_data_i
                                                               : r_minstret_hi + XLEN'(w_ir_carry);
    end
  end
`else
  logic w_unused_instret;
  assign w_unused_instret = instret_v_i;
`endif

  always_comb begin
    csr_rd_data_o    = '0;
    csr_rd_illegal_o = 1'b0;
    case (csr_rd_adr_i)
      A_MSTATUS:  csr_rd_data_o = XLEN'({19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0});
      A_MISA:     csr_rd_data_o = XLEN'(32'h4000_0100);
      A_MIE:      csr_rd_data_o = '0;
      A_MIP:      csr_rd_data_o = '0;
      A_MTVEC:    csr_rd_data_o = r_mtvec;
      A_MSCRATCH: csr_rd_data_o = r_mscratch;
      A_MEPC:     csr_rd_data_o = r_mepc;
      A_MCAUSE:   csr_rd_data_o = r_mcause;
      A_MTVAL:    csr_rd_data_o = r_mtval;
      A_MHARTID:  csr_rd_data_o = XLEN'(HART_ID);
`ifdef CSR_COUNTERS_EN
      A_MCYCLE,   A_CYCLE:    csr_rd_data_o = r_mcycle_lo;
      A_MCYCLEH,  A_CYCLEH:   csr_rd_data_o = r_mcycle_hi;
      A_MINSTRET, A_INSTRET:  csr_rd_data_o = r_minstret_lo;
      A_MINSTRETH, A_INSTRETH: csr_rd_data_o = r_minstret_hi;
`endif
      default:    csr_rd_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed literal checks plus randomized traffic
// compared every cycle against an architectural model of the CSR state.
`timescale 1ns/1ps
module tb_csr_file;
  localparam logic [31:0] MTVEC_RST = 32'h0000_0040;
  localparam int unsigned HID       = 3;

  logic        clk, reset;
  logic        csr_wbk_v_i;
  logic [11:0] csr_wbk_adr_i;
  logic [31:0] csr_wbk_data_i;
  logic [11:0] csr_rd_adr_i;
  logic [31:0] csr_rd_data_o;
  logic        csr_rd_illegal_o;
  logic        exception_v_i;
  logic [31:0] exception_cause_i, exception_pc_i, exception_tval_i;
  logic        mret_v_i, instret_v_i;
  logic        trap_v_q_o;
  logic [31:0] trap_pc_q_o;

  int checks = 0;
  int errors = 0;

  csr_file #(.XLEN(32), .MTVEC_RESET(MTVEC_RST), .HART_ID(HID)) dut (
    .clk(clk), .reset(reset),
    .csr_wbk_v_i(csr_wbk_v_i), .csr_wbk_adr_i(csr_wbk_adr_i), .csr_wbk_data_i(csr_wbk_data_i),
    .csr_rd_adr_i(csr_rd_adr_i), .csr_rd_data_o(csr_rd_data_o), .csr_rd_illegal_o(csr_rd_illegal_o),
    .exception_v_i(exception_v_i), .exception_cause_i(exception_cause_i),
    .exception_pc_i(exception_pc_i), .exception_tval_i(exception_tval_i),
    .mret_v_i(mret_v_i), .instret_v_i(instret_v_i),
    .trap_v_q_o(trap_v_q_o), .trap_pc_q_o(trap_pc_q_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- architectural model ----------------
  logic        mv = 1'b0;
  logic        m_mie, m_mpie, m_tv;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_tpc;
  logic [63:0] m_cyc, m_ins;

  always @(posedge clk) begin
    logic wr;
    logic [63:0] c, i;
    if (reset) begin
      mv = 1'b1; m_mie = 0; m_mpie = 0; m_tv = 0; m_tpc = 0;
      m_mtvec = MTVEC_RST; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
      m_cyc = 0; m_ins = 0;
    end else begin
      wr = csr_wbk_v_i && !exception_v_i && !mret_v_i;
      c = m_cyc + 64'd1;
      i = m_ins + (instret_v_i ? 64'd1 : 64'd0);
      m_tv = exception_v_i || mret_v_i;
      if (exception_v_i) begin
        m_tpc = m_mtvec;
        m_mepc = exception_pc_i & 32'hFFFF_FFFC;
        m_mcause = exception_cause_i;
        m_mtval = exception_tval_i;
        m_mpie = m_mie;
        m_mie = 1'b0;
      end else if (mret_v_i) begin
        m_tpc = m_mepc;
        m_mie = m_mpie;
        m_mpie = 1'b1;
      end else if (wr) begin
        case (csr_wbk_adr_i)
          12'h300: begin m_mie = csr_wbk_data_i[3]; m_mpie = csr_wbk_data_i[7]; end
          12'h305: m_mtvec = csr_wbk_data_i & 32'hFFFF_FFFC;
          12'h340: m_mscratch = csr_wbk_data_i;
          12'h341: m_mepc = csr_wbk_data_i & 32'hFFFF_FFFC;
          12'h342: m_mcause = csr_wbk_data_i;
          12'h343: m_mtval = csr_wbk_data_i;
          12'hB00: c[31:0]  = csr_wbk_data_i;
          12'hB80: c[63:32] = csr_wbk_data_i;
          12'hB02: i[31:0]  = csr_wbk_data_i;
          12'hB82: i[63:32] = csr_wbk_data_i;
          default: ;
        endcase
      end
      m_cyc = c;
      m_ins = i;
    end
  end

  function automatic void mread(input logic [11:0] a, output logic [31:0] d, output logic ill);
    d = 0; ill = 0;
    case (a)
      12'h300: d = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h301: d = 32'h4000_0100;
      12'h304, 12'h344: d = 0;
      12'h305: d = m_mtvec;
      12'h340: d = m_mscratch;
      12'h341: d = m_mepc;
      12'h342: d = m_mcause;
      12'h343: d = m_mtval;
      12'hF14: d = HID;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: d = m_cyc[31:0];
      12'hB80, 12'hC80: d = m_cyc[63:32];
      12'hB02, 12'hC02: d = m_ins[31:0];
      12'hB82, 12'hC82: d = m_ins[63:32];
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [31:0] d;
    logic ill;
    if (mv) begin
      mread(csr_rd_adr_i, d, ill);
      chk($sformatf("cmp_rd_%h", csr_rd_adr_i), csr_rd_data_o, d);
      chk($sformatf("cmp_ill_%h", csr_rd_adr_i), 32'(csr_rd_illegal_o), 32'(ill));
      chk("cmp_trap_v", 32'(trap_v_q_o), 32'(m_tv));
      chk("cmp_trap_pc", trap_pc_q_o, m_tpc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csr_wbk_v_i = 0; csr_wbk_adr_i = 0; csr_wbk_data_i = 0;
    exception_v_i = 0; exception_cause_i = 0; exception_pc_i = 0; exception_tval_i = 0;
    mret_v_i = 0; instret_v_i = 0;
  endtask

  task automatic wbk(input logic [11:0] a, input logic [31:0] d);
    csr_wbk_v_i = 1; csr_wbk_adr_i = a; csr_wbk_data_i = d;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input logic exp_ill);
    csr_rd_adr_i = a;
    #1;
    chk($sformatf("rd_%h", a), csr_rd_data_o, exp);
    chk($sformatf("ill_%h", a), 32'(csr_rd_illegal_o), 32'(exp_ill));
  endtask

  logic [11:0] addrs [24] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                              12'h342, 12'h343, 12'h344, 12'hF14, 12'hB00, 12'hB80,
                              12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82,
                              12'h7C0, 12'h000, 12'h305, 12'h341, 12'h300, 12'h340};

  initial begin
    idle();
    reset = 1; csr_rd_adr_i = 12'h301;
    repeat (2) cyc();
    reset = 0;
    rd(12'h301, 32'h4000_0100, 0);
    rd(12'hF14, HID, 0);
    rd(12'h300, 32'h0000_1800, 0);
    rd(12'h7C0, 32'h0, 1);
    rd(12'h305, MTVEC_RST, 0);
    chk("rst_trap_v", 32'(trap_v_q_o), 32'h0);
    chk("rst_trap_pc", trap_pc_q_o, 32'h0);

    cyc(); wbk(12'h305, 32'h8000_0103);
    rd(12'h305, MTVEC_RST, 0);
    cyc(); idle();
    rd(12'h305, 32'h8000_0100, 0);

    wbk(12'h300, 32'h0000_0008);
    cyc(); idle();
    exception_v_i = 1; exception_cause_i = 4; exception_pc_i = 32'h1006; exception_tval_i = 32'h1234;
    rd(12'h300, 32'h0000_1808, 0);

    cyc(); idle();
    mret_v_i = 1; wbk(12'h340, 32'hDEAD_BEEF);
    chk("exc_trap_v", 32'(trap_v_q_o), 32'h1);
    chk("exc_trap_pc", trap_pc_q_o, 32'h8000_0100);
    rd(12'h341, 32'h1004, 0);
    rd(12'h342, 32'h4, 0);
    rd(12'h343, 32'h1234, 0);
    rd(12'h300, 32'h0000_1880, 0);

    cyc(); idle();
    exception_v_i = 1; exception_cause_i = 11; exception_pc_i = 32'h2003;
    mret_v_i = 1; wbk(12'h341, 32'h5555_5555);
    chk("mret_trap_v", 32'(trap_v_q_o), 32'h1);
    chk("mret_trap_pc", trap_pc_q_o, 32'h1004);
    rd(12'h300, 32'h0000_1888, 0);
    rd(12'h340, 32'h0, 0);

    cyc(); idle();
    chk("both_trap_v", 32'(trap_v_q_o), 32'h1);
    chk("both_trap_pc", trap_pc_q_o, 32'h8000_0100);
    rd(12'h341, 32'h2000, 0);
    rd(12'h342, 32'd11, 0);
    rd(12'h300, 32'h0000_1880, 0);

    cyc();
    chk("idle_trap_v", 32'(trap_v_q_o), 32'h0);
    chk("idle_trap_pc", trap_pc_q_o, 32'h8000_0100);

`ifdef CSR_COUNTERS_EN
    wbk(12'hB80, 32'h0);
    cyc(); wbk(12'hB00, 32'hFFFF_FFFF);
    cyc(); idle();
    rd(12'hB00, 32'hFFFF_FFFF, 0);
    rd(12'hB80, 32'h0, 0);
    cyc();
    rd(12'hB00, 32'h0, 0);
    rd(12'hB80, 32'h1, 0);
    rd(12'hC80, 32'h1, 0);
    wbk(12'hB02, 32'h0);
    cyc(); wbk(12'hB82, 32'h0);
    cyc(); idle();
    for (int k = 0; k < 5; k++) begin
      instret_v_i = 1;
      cyc();
    end
    instret_v_i = 0;
    rd(12'hB02, 32'd5, 0);
    rd(12'hC02, 32'd5, 0);
    rd(12'hB82, 32'd0, 0);
`else
    rd(12'hB00, 32'h0, 1);
    rd(12'hC02, 32'h0, 1);
`endif

    // reset overrides a simultaneous exception
    exception_v_i = 1; exception_pc_i = 32'h3000; reset = 1;
    cyc(); idle(); reset = 0;
    chk("rstov_trap_v", 32'(trap_v_q_o), 32'h0);
    rd(12'h305, MTVEC_RST, 0);
    rd(12'h341, 32'h0, 0);

    for (int n = 0; n < 4000; n++) begin
      cyc();
      idle();
      reset = ($urandom_range(0, 299) == 0);
      csr_rd_adr_i = addrs[$urandom_range(0, 23)];
      if ($urandom_range(0, 2) == 0) begin
        csr_wbk_v_i = 1;
        csr_wbk_adr_i = addrs[$urandom_range(0, 23)];
        csr_wbk_data_i = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
      if ($urandom_range(0, 9) == 0) begin
        int c;
        c = $urandom_range(0, 8);
        exception_v_i = 1;
        exception_cause_i = (c == 8) ? 32'd11 : 32'(c);
        exception_pc_i = $urandom;
        exception_tval_i = $urandom_range(0, 1) ? $urandom : 32'h0;
      end
      mret_v_i = ($urandom_range(0, 9) == 0);
      instret_v_i = $urandom_range(0, 1) == 1;
    end
    cyc(); idle(); reset = 0;
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
